serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Bit-serial add sequencer. It time-shares a single adder_1bit instance to add two WIDTH-bit operands, one bit per clock, LSB first. The carry is held in a flop between bit slices. It is the area-minimal alternative to the 8-bit ripple adder, with a start/busy/done handshake toward the requester.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request an add; accepted only when busy=0
A  input  WIDTH  operand A, sampled on the accepting edge only
B  input  WIDTH  operand B, sampled on the accepting edge only
Cin  input  1  carry-in, sampled on the accepting edge only
busy  output  1  high while bit slices are being computed
done  output  1  one-cycle pulse: S/Cout valid
S  output  WIDTH  registered sum, held until the next result
Cout  output  1  registered carry-out, held with S

Behaviour:
- Reset (rst=1 at a clock edge, priority over everything): state=IDLE; busy=0, done=0, S=0, Cout=0; shift regs, carry flop and bit counter cleared.
- Internal state: a_sh, b_sh, s_sh (WIDTH each); carry flop c; counter cnt, $clog2(WIDTH+1) bits.
- Single adder_1bit instance: inputs a_sh[0], b_sh[0], c; outputs s_bit, c_next. Exactly one instance; no other adder logic.
- States: IDLE, ADD, DONE.
- IDLE: busy=0, done=0. On start=1: a_sh<=A, b_sh<=B, c<=Cin, cnt<=0, go to ADD.
- ADD: busy=1, done=0. On each edge:
  - a_sh and b_sh shift right by 1.
  - s_sh shifts right with s_bit into the MSB.
  - c<=c_next; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: S<={s_bit, s_sh[WIDTH-1:1]}, Cout<=c_next, go to DONE.
  - For WIDTH=1, S<=s_bit.
- DONE: busy=0, done=1 for exactly this cycle.
  - On start=1: accept new operands (same actions as IDLE) and go to ADD.
  - Otherwise go to IDLE.
- Latency: start sampled on edge E0 -> busy high for cycles E0+1..E0+WIDTH -> done high and S/Cout valid in cycle E0+WIDTH+1 (9 cycles for WIDTH=8). Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start while busy=1: ignored. It is not queued, and operands are not resampled.
- A/B/Cin changes after acceptance: no effect on the in-flight add.
- S/Cout: change only on the final ADD edge or on reset. They stay stable through IDLE and through a following ADD sequence (they show the previous result).
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-ADD: aborts immediately. The next cycle is IDLE with all outputs 0, and done is never pulsed for the aborted operation.
- Unknown/illegal state encoding: recover to IDLE on the next edge.

Test Plan:
1. Reset: hold rst=1 for 2 cycles, then release -> busy=0, done=0, S=0x00, Cout=0. Idle for 5 cycles with start=0 -> outputs unchanged.
2. Basic add, WIDTH=8: A=0x5A, B=0x3C, Cin=0, start pulsed 1 cycle -> busy high for exactly 8 cycles, then done=1 for 1 cycle with S=0x96, Cout=0. S still 0x96 10 cycles later.
3. Carry corners, one run each:
   - 0xFF+0x01, Cin=0 -> S=0x00, Cout=1
   - 0xFF+0xFF, Cin=1 -> S=0xFF, Cout=1
   - 0x00+0x00, Cin=1 -> S=0x01, Cout=0
4. Start while busy: start 0x10+0x20. Three cycles later, assert start with A=0xAA, B=0x55 -> ignored; result is S=0x30, Cout=0 with done at the normal cycle. Only one done pulse.
5. Back-to-back: assert start in the done cycle of 0x01+0x01 (result 0x02) with A=0x80, B=0x80 -> busy rises next cycle. Second done arrives 9 cycles later with S=0x00, Cout=1.
6. Reset mid-op: start 0x7F+0x01, assert rst at the 4th busy cycle -> next cycle busy=0, S=0x00, Cout=0, no done pulse. A subsequent 0x03+0x04 -> S=0x07 after 9 cycles.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer.
// Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first.
// A single adder_1bit is time-shared across all bit slices. The carry is held
// in a flop between slices.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active high, priority over everything
//   start       request an add; accepted only when busy=0 (IDLE or DONE)
//   A, B, Cin   operands, sampled only on the accepting edge
//   busy        high while bit slices are being computed (WIDTH cycles)
//   done        one-cycle pulse, S/Cout valid
//   S, Cout     registered result, held until the next result or reset

module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic s_bit, c_next;

  adder_1bit u_add (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (c_q),
    .s  (s_bit),
    .co (c_next)
  );

  // Sum register shifts right with the new bit entering at the MSB; this
  // form also covers WIDTH=1, where the shifted value is just s_bit.
  logic [WIDTH:0]   s_cat;
  logic [WIDTH-1:0] s_shift;
  logic             unused_lsb;
  assign s_cat      = {s_bit, s_sh_q};
  assign s_shift    = s_cat[WIDTH:1];
  assign unused_lsb = s_cat[0];

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          c_d     = Cin;
          cnt_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = s_shift;
        c_d    = c_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          s_d     = s_shift;
          cout_d  = c_next;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule
